// File: rtl/trigger_input_conditioner.sv
// Trigger input conditioner: synchronises, glitch-filters and edge-detects start/fg/wire inputs.
// Define EVENT_COUNT_EN to build the saturating per-channel pulse counters.
module trigger_input_conditioner_channel #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int HOLDOFF     = 1000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic arm,
    input  logic raw_i,
    output logic pulse_o,
    output logic level_o
);
    localparam int QW = $clog2(FILTER_LEN + 1);
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [QW-1:0] Q_LAST = QW'(FILTER_LEN - 1);
    localparam logic [HW-1:0] H_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [2:0] {
        S_WAIT_LOW,
        S_LOW,
        S_RISE_QUAL,
        S_HIGH,
        S_FALL_QUAL,
        S_HOLD
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    state_t                 state_q;
    logic [QW-1:0]          qcnt_q;
    logic [HW-1:0]          hcnt_q;
    logic                   level_q;
    logic                   pulse_q;
    logic                   s;

    assign s       = sync_q[SYNC_STAGES-1];
    assign pulse_o = pulse_q;
    assign level_o = level_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= S_WAIT_LOW;
            qcnt_q  <= '0;
            hcnt_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            pulse_q <= 1'b0;
            case (state_q)
                S_WAIT_LOW: begin
                    if (s) begin
                        qcnt_q <= '0;
                    end else if (qcnt_q == Q_LAST) begin
                        state_q <= S_LOW;
                        qcnt_q  <= '0;
                    end else begin
                        qcnt_q <= qcnt_q + QW'(1);
                    end
                end
                // LOW is the zero-count entry of the rise qualifier.
                S_LOW, S_RISE_QUAL: begin
                    if (!s) begin
                        state_q <= S_LOW;
                        qcnt_q  <= '0;
                    end else if (qcnt_q == Q_LAST) begin
                        state_q <= S_HIGH;
                        qcnt_q  <= '0;
                        level_q <= 1'b1;
                        pulse_q <= arm;
                    end else begin
                        state_q <= S_RISE_QUAL;
                        qcnt_q  <= qcnt_q + QW'(1);
                    end
                end
                S_HIGH, S_FALL_QUAL: begin
                    if (s) begin
                        state_q <= S_HIGH;
                        qcnt_q  <= '0;
                    end else if (qcnt_q == Q_LAST) begin
                        state_q <= (HOLDOFF == 0) ? S_LOW : S_HOLD;
                        qcnt_q  <= '0;
                        hcnt_q  <= '0;
                        level_q <= 1'b0;
                    end else begin
                        state_q <= S_FALL_QUAL;
                        qcnt_q  <= qcnt_q + QW'(1);
                    end
                end
                S_HOLD: begin
                    if (hcnt_q == H_LAST) begin
                        state_q <= S_LOW;
                        hcnt_q  <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + HW'(1);
                    end
                end
                default: begin
                    state_q <= S_WAIT_LOW;
                    qcnt_q  <= '0;
                    hcnt_q  <= '0;
                end
            endcase
        end
    end
endmodule

module trigger_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int HOLDOFF     = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             count_clear,
    input  logic             start_raw,
    input  logic             fg_raw,
    input  logic             wire_raw,
    output logic             start_signal,
    output logic             fg_signal,
    output logic             wire_signal,
    output logic [2:0]       level_out,
    output logic [CNT_W-1:0] start_count,
    output logic [CNT_W-1:0] fg_count,
    output logic [CNT_W-1:0] wire_count
);
    logic [2:0] raw;
    logic [2:0] pulse;
    logic [2:0] level;

    assign raw = {wire_raw, fg_raw, start_raw};

    for (genvar c = 0; c < 3; c++) begin : g_ch
        trigger_input_conditioner_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN),
            .HOLDOFF    (HOLDOFF)
        ) u_ch (
            .clock  (clock),
            .reset_n(reset_n),
            .arm    (arm),
            .raw_i  (raw[c]),
            .pulse_o(pulse[c]),
            .level_o(level[c])
        );
    end

    assign start_signal = pulse[0];
    assign fg_signal    = pulse[1];
    assign wire_signal  = pulse[2];
    assign level_out    = level;

`ifdef EVENT_COUNT_EN
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            cnt_d[c] = cnt_q[c];
            if (count_clear) begin
                cnt_d[c] = '0;
            end else if (pulse[c] && (cnt_q[c] != '1)) begin
                cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < 3; c++) begin
            if (!reset_n) begin
                cnt_q[c] <= '0;
            end else begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign start_count = cnt_q[0];
    assign fg_count    = cnt_q[1];
    assign wire_count  = cnt_q[2];
`else
    logic unused_count_clear;

    assign unused_count_clear = count_clear;
    assign start_count        = '0;
    assign fg_count           = '0;
    assign wire_count         = '0;
`endif
endmodule
